rl_hdr_crc_check: RTL and testbench

- Receive-side counterpart of the serial CRC-16 generator used by the RL02 controller.
- Takes a deserialized header bitstream from the drive read path: two 16-bit header words followed by a 16-bit CRC.
- Assembles the header words, recomputes the CRC over the data bits and compares it with the received CRC.
- Reports the result to the sector-search logic, which uses `crc_ok` to qualify a header before trusting cylinder/sector fields.

---
 rtl/rl_hdr_crc_check.sv | 141 ++++++++++++++
 tb/tb_rl_hdr_crc_check.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_hdr_crc_check.sv
// Receive-side RL02 header checker: assembles two 16-bit header words, recomputes the CRC-16 and compares it with the received CRC.
// Optional CRC-mismatch counter enabled by defining RL_CRC_ERRCNT_EN; otherwise err_count is tied to zero.
module rl_hdr_crc_check #(
  parameter logic [15:0] POLY           = 16'h8005,
  parameter logic [15:0] SEED           = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        err_timeout,
  output logic [15:0] hdr_word0,
  output logic [15:0] hdr_word1,
  output logic [15:0] crc_rx,
  output logic [15:0] crc_calc,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CRCF,
    S_DONE
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] crc;
  logic [15:0] to_cnt;
  logic [5:0]  bit_cnt;

  logic        fb;
  logic [15:0] crc_next;
  logic        to_hit;

  always_comb begin
    fb       = bit_in ^ crc[15];
    crc_next = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    // The cycle that would bring the idle count up to the limit is the abort cycle.
    to_hit   = !bit_valid && (to_cnt >= TO_LIMIT - 16'd1);
  end

  // NOTE: all state below is assigned with non-blocking (<=) so every register
  // samples pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      crc         <= SEED;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      err_timeout <= 1'b0;
      hdr_word0   <= '0;
      hdr_word1   <= '0;
      crc_rx      <= '0;
      crc_calc    <= SEED;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;

      if (start) begin
        // Restart from any state; a same-cycle bit_valid is deliberately dropped.
        state     <= S_DATA;
        crc       <= SEED;
        bit_cnt   <= '0;
        to_cnt    <= '0;
        busy      <= 1'b1;
        crc_ok    <= 1'b0;
        hdr_word0 <= '0;
        hdr_word1 <= '0;
        crc_rx    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
          end

          S_DATA, S_CRCF: begin
            if (bit_valid) begin
              to_cnt  <= '0;
              bit_cnt <= bit_cnt + 6'd1;
              if (state == S_DATA) begin
                crc <= crc_next;
                if (!bit_cnt[4]) hdr_word0[bit_cnt[3:0]] <= bit_in;
                else             hdr_word1[bit_cnt[3:0]] <= bit_in;
                if (bit_cnt == 6'd31) begin
                  crc_calc <= crc_next;
                  state    <= S_CRCF;
                end
              end else begin
                crc_rx <= {crc_rx[14:0], bit_in};
                if (bit_cnt == 6'd47) state <= S_DONE;
              end
            end else if (to_hit) begin
              err_timeout <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end else if (to_cnt != 16'hFFFF) begin
              to_cnt <= to_cnt + 16'd1;
            end
          end

          S_DONE: begin
            done   <= 1'b1;
            crc_ok <= (crc_calc == crc_rx);
            busy   <= 1'b0;
            state  <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef RL_CRC_ERRCNT_EN
  logic mismatch_done;

  // Counts on the same edge that raises done with a failing compare.
  assign mismatch_done = (state == S_DONE) && !start && (crc_calc != crc_rx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (mismatch_done && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rl_hdr_crc_check.sv
// Self-checking bench for rl_hdr_crc_check: directed vector table, hand-written corner sequences,
// and random frames checked against a polynomial-division CRC model.
module tb_rl_hdr_crc_check;

  localparam logic [15:0] POLY    = 16'h8005;
  localparam logic [15:0] SEED    = 16'h0000;
  localparam int          TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        bit_in;
  logic        bit_valid;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        err_timeout;
  logic [15:0] hdr_word0;
  logic [15:0] hdr_word1;
  logic [15:0] crc_rx;
  logic [15:0] crc_calc;
  logic [15:0] err_count;

  rl_hdr_crc_check #(
    .POLY          (POLY),
    .SEED          (SEED),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .err_timeout(err_timeout),
    .hdr_word0  (hdr_word0),
    .hdr_word1  (hdr_word1),
    .crc_rx     (crc_rx),
    .crc_calc   (crc_calc),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int n_done   = 0;
  int n_to     = 0;
  int exp_errs = 0;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done)        n_done++;
      if (err_timeout) n_to++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC: remainder of (SEED*x^32 + M*x^16) mod P, first transmitted bit as highest power.
  function automatic logic [15:0] ref_crc(input logic [15:0] w0, input logic [15:0] w1);
    logic [47:0] v;
    logic [16:0] g;
    g = {1'b1, POLY};
    v = '0;
    for (int k = 0; k < 32; k++) v[47-k] = (k < 16) ? w0[k] : w1[k-16];
    v[47:32] = v[47:32] ^ SEED;
    for (int i = 47; i >= 16; i--) if (v[i]) v[i -: 17] = v[i -: 17] ^ g;
    return v[15:0];
  endfunction

  function automatic logic stream_bit(input logic [15:0] w0, input logic [15:0] w1,
                                      input logic [15:0] c, input int idx);
    if (idx < 16) return w0[idx];
    if (idx < 32) return w1[idx-16];
    return c[15-(idx-32)];
  endfunction

  function automatic logic [15:0] err_expect();
`ifdef RL_CRC_ERRCNT_EN
    return 16'(exp_errs);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic pulse_start(input logic with_valid);
    start     = 1'b1;
    bit_valid = with_valid;
    bit_in    = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  // Full frame: start, 48 bits (optional random gaps / one long gap), then done latency and result checks.
  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] crc_s,
                           input int gap_max, input int long_gap_at, input logic start_valid,
                           input string tag, input logic [15:0] exp_calc, input logic exp_ok);
    int d0;
    d0 = n_done;
    pulse_start(start_valid);
    check({tag, "_okclr"}, {31'd0, crc_ok}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 48; i++) begin
      if (i == long_gap_at) begin
        bit_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
      end else if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          bit_valid = 1'b0;
          bit_in    = 1'($urandom);
          tick();
        end
      end
      bit_valid = 1'b1;
      bit_in    = stream_bit(w0, w1, crc_s, i);
      tick();
    end
    bit_valid = 1'b0;
    check({tag, "_nodone_early"}, {31'd0, done}, 32'd0);
    tick();
    if (!exp_ok) exp_errs++;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_hdr0"}, {16'd0, hdr_word0}, {16'd0, w0});
    check({tag, "_hdr1"}, {16'd0, hdr_word1}, {16'd0, w1});
    check({tag, "_crc_rx"}, {16'd0, crc_rx}, {16'd0, crc_s});
    check({tag, "_crc_calc"}, {16'd0, crc_calc}, {16'd0, exp_calc});
    check({tag, "_crc_ok"}, {31'd0, crc_ok}, {31'd0, exp_ok});
    check({tag, "_err_count"}, {16'd0, err_count}, {16'd0, err_expect()});
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_ok"}, {31'd0, crc_ok}, {31'd0, exp_ok});
    check({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] crc_s;
    logic [15:0] exp_calc;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] w0, w1, good, sent, hold0;
    int          d0, t0;
    logic        corrupt;

    vecs[0] = '{"zero",    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[1] = '{"single",  16'h0000, 16'h8000, 16'h8005, 16'h8005, 1'b1};
    vecs[2] = '{"single2", 16'h0000, 16'h4000, 16'h800F, 16'h800F, 1'b1};
    vecs[3] = '{"corrupt", 16'h0000, 16'h8000, 16'h8004, 16'h8005, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
    check("rst_timeout", {31'd0, err_timeout}, 32'd0);
    check("rst_hdr", {hdr_word1, hdr_word0}, 32'd0);
    check("rst_crc_rx", {16'd0, crc_rx}, 32'd0);
    check("rst_crc_calc", {16'd0, crc_calc}, {16'd0, SEED});
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors, back-to-back bits.
    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].w0, vecs[v].w1, vecs[v].crc_s, 0, -1, 1'b0,
                vecs[v].name, vecs[v].exp_calc, vecs[v].exp_ok);

    // Longest legal gap (one cycle short of the timeout) must not abort.
    w0   = 16'hA5C3;
    w1   = 16'h1E77;
    good = ref_crc(w0, w1);
    run_frame(w0, w1, good, 0, 20, 1'b0, "longgap", good, 1'b1);
    check("longgap_no_timeout", 32'(n_to), 32'd0);

    // Random frames with random gaps and occasional single-bit CRC corruption.
    for (int r = 0; r < 20; r++) begin
      w0      = 16'($urandom);
      w1      = 16'($urandom);
      good    = ref_crc(w0, w1);
      corrupt = ($urandom_range(0, 2) == 0);
      sent    = corrupt ? (good ^ (16'h0001 << $urandom_range(0, 15))) : good;
      run_frame(w0, w1, sent, 3, -1, 1'b0, $sformatf("rnd%0d", r), good, !corrupt);
    end

    // Timeout: 20 bits then bit_valid held low.
    d0 = n_done;
    t0 = n_to;
    w0 = 16'h3C5A;
    w1 = 16'h000F;
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      bit_valid = 1'b1;
      bit_in    = stream_bit(w0, w1, 16'h0000, i);
      tick();
    end
    bit_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("to_not_yet", {31'd0, err_timeout}, 32'd0);
    check("to_busy_before", {31'd0, busy}, 32'd1);
    tick();
    check("to_pulse", {31'd0, err_timeout}, 32'd1);
    check("to_busy_after", {31'd0, busy}, 32'd0);
    check("to_partial_hdr0", {16'd0, hdr_word0}, {16'd0, w0});
    check("to_partial_hdr1", {16'd0, hdr_word1}, {28'd0, w1[3:0]});
    tick();
    check("to_pulse_end", {31'd0, err_timeout}, 32'd0);
    hold0 = hdr_word0;
    bit_valid = 1'b1;
    repeat (6) begin
      bit_in = ~bit_in;
      tick();
    end
    bit_valid = 1'b0;
    tick();
    check("idle_bits_busy", {31'd0, busy}, 32'd0);
    check("idle_bits_hdr0", {16'd0, hdr_word0}, {16'd0, hold0});
    check("to_count", 32'(n_to - t0), 32'd1);
    check("to_no_done", 32'(n_done - d0), 32'd0);

    // Restart after 40 bits, with bit_valid in the restart cycle ignored.
    d0 = n_done;
    pulse_start(1'b0);
    for (int i = 0; i < 40; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      tick();
    end
    run_frame(16'h0000, 16'h0000, 16'h0000, 0, -1, 1'b1, "restart", 16'h0000, 1'b1);
    check("restart_one_done", 32'(n_done - d0), 32'd1);

    // Asynchronous reset mid-frame after a failing frame left nonzero outputs.
    run_frame(16'h0000, 16'h8000, 16'h8004, 0, -1, 1'b0, "prerst", 16'h8005, 1'b0);
    d0 = n_done;
    t0 = n_to;
    pulse_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_errs = 0;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hdr", {hdr_word1, hdr_word0}, 32'd0);
    check("arst_crc_rx", {16'd0, crc_rx}, 32'd0);
    check("arst_crc_calc", {16'd0, crc_calc}, {16'd0, SEED});
    check("arst_crc_ok", {31'd0, crc_ok}, 32'd0);
    check("arst_err_count", {16'd0, err_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (TIMEOUT + 4) tick();
    check("arst_no_done", 32'(n_done - d0), 32'd0);
    check("arst_no_timeout", 32'(n_to - t0), 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
